// File: rtl/mem_model_pkg.sv
// Shared types and constants for the Avalon-MM memory model: FSM states,
// wait-randomiser LFSR constants and the default CPU reset-vector base.
`timescale 1ns/1ps
package mem_model_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1, right-shifting Galois form
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC0_0000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/mem_wait_lfsr.sv
// 8-bit Galois LFSR that supplies 0..3 extra wait cycles per transfer.
`timescale 1ns/1ps
module mem_wait_lfsr
  import mem_model_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [1:0] wait_extra
);

  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign wait_extra = lfsr[1:0];

endmodule

// File: rtl/avalon_mem_model.sv
// Avalon-MM slave memory model with fixed wait states, clocked preload port
// and sticky error flag. Define MEM_WAIT_RANDOM_EN for LFSR-randomised waits.
`timescale 1ns/1ps
module avalon_mem_model
  import mem_model_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              address,
  input  logic                     read,
  input  logic                     write,
  input  logic [DATA_W-1:0]        writedata,
  input  logic [DATA_W/8-1:0]      byteenable,
  output logic                     waitrequest,
  output logic [DATA_W-1:0]        readdata,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 4) + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_total;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             req;
  logic             start;
  logic             access;
  logic             in_range;
  logic             bad;

  assign req   = read | write;
  assign start = reset && req && (state == IDLE);

`ifdef MEM_WAIT_RANDOM_EN
  logic [1:0] wait_extra;

  mem_wait_lfsr u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .en         (start),
    .wait_extra (wait_extra)
  );

  assign wait_total = CNT_W'(WAIT_CYCLES) + CNT_W'(wait_extra);
`else
  assign wait_total = CNT_W'(WAIT_CYCLES);
`endif

  // A zero-wait transfer completes straight out of IDLE; reset gates all access.
  assign access = reset && req &&
                  ((state == ACCESS) || ((state == IDLE) && (wait_total == '0)));

  assign offset      = address - BASE_ADDR;
  assign in_range    = offset < 32'(DEPTH * 4);
  assign idx         = offset[IDX_W+1:2];
  assign bad         = !in_range || (address[1:0] != 2'b00) || (read && write);
  assign waitrequest = req && !access;
  assign readdata    = (access && read && in_range) ? mem[idx] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && (wait_total != '0)) begin
            cnt   <= wait_total;
            state <= (wait_total == CNT_W'(1)) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt <= CNT_W'(2)) state <= ACCESS;
          end
        end
        ACCESS: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
      if (access && bad) err <= 1'b1;
    end
  end

  // Preload is written last so it wins a same-edge collision with a bus write.
  always_ff @(posedge clk) begin
    if (access && write && !read && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
    if (load_en) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_avalon_mem_model.sv
// Self-checking bench for avalon_mem_model: four instances with different
// wait-state settings share clock, reset and the preload port.
`timescale 1ns/1ps
module tb_avalon_mem_model;
  import mem_model_pkg::*;

  localparam int          NI    = 4;
  localparam int          I_W2  = 0;
  localparam int          I_W0  = 1;
  localparam int          I_W3  = 2;
  localparam int          I_W1  = 3;
  localparam logic [31:0] BASE  = DEFAULT_BASE_ADDR;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address    [NI];
  logic        bus_read   [NI];
  logic        bus_write  [NI];
  logic [31:0] writedata  [NI];
  logic [3:0]  byteenable [NI];
  logic        waitreq    [NI];
  logic [31:0] readdata   [NI];
  logic        err_s      [NI];
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    avalon_mem_model #(
      .DATA_W      (32),
      .DEPTH       (256),
      .BASE_ADDR   (BASE),
      .WAIT_CYCLES (g == 0 ? 2 : (g == 1 ? 0 : (g == 2 ? 3 : 1)))
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .address     (address[g]),
      .read        (bus_read[g]),
      .write       (bus_write[g]),
      .writedata   (writedata[g]),
      .byteenable  (byteenable[g]),
      .waitrequest (waitreq[g]),
      .readdata    (readdata[g]),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .err         (err_s[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] off;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 ns after a rising edge.
  task automatic preload(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = idx[7:0];
    load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic bus(input int i, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rdata, output int waits, output logic err_after);
    logic done;
    done  = 1'b0;
    waits = 0;
    rdata = '0;
    address[i]    = addr;
    writedata[i]  = wd;
    byteenable[i] = be;
    bus_read[i]   = rd;
    bus_write[i]  = wr;
    while (!done && waits < 16) begin
      @(negedge clk);
      if (!waitreq[i]) begin
        done  = 1'b1;
        rdata = readdata[i];
      end else begin
        waits++;
      end
    end
    @(posedge clk); #1;
    bus_read[i]  = 1'b0;
    bus_write[i] = 1'b0;
    err_after    = err_s[i];
    check("bus_complete", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdata;
    logic        e;
    int          waits;
    int          total;
    logic [7:0]  lfsr_m;

    vecs[0] = '{1'b1, 1'b0, 32'd4,    32'h0,        4'h0, 32'h2402_0010};
    vecs[1] = '{1'b0, 1'b1, 32'd12,   32'hAABB_CCDD, 4'h5, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'd12,   32'h0,        4'h0, 32'h11BB_33DD};
    vecs[3] = '{1'b0, 1'b1, 32'd0,    32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'd0,    32'h0,        4'h0, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b1, 32'd0,    32'h0000_0000, 4'h6, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'd0,    32'h0,        4'h0, 32'hDE00_00EF};
    vecs[7] = '{1'b0, 1'b1, 32'd8,    32'h1234_5678, 4'h8, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'd8,    32'h0,        4'h0, 32'h1200_0000};
    vecs[9] = '{1'b1, 1'b0, 32'd1020, 32'h0,        4'h0, 32'hCAFE_F00D};

    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    for (int k = 0; k < NI; k++) begin
      address[k]    = BASE;
      bus_read[k]   = 1'b0;
      bus_write[k]  = 1'b0;
      writedata[k]  = '0;
      byteenable[k] = '0;
    end

    // Held in reset with requests pending: master must stall, nothing returned.
    bus_read[I_W2] = 1'b1;
    bus_read[I_W0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_waitreq_w2", 32'(waitreq[I_W2]), 32'd1);
    check("rst_waitreq_w0", 32'(waitreq[I_W0]), 32'd1);
    check("rst_readdata_w0", readdata[I_W0], 32'h0);
    check("rst_err", 32'(err_s[I_W2]), 32'd0);
    bus_read[I_W2] = 1'b0;
    bus_read[I_W0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    preload(1,   32'h2402_0010);
    preload(2,   32'h0000_0000);
    preload(3,   32'h1122_3344);
    preload(5,   32'h5555_5555);
    preload(255, 32'hCAFE_F00D);

    foreach (vecs[v]) begin
      bus(I_W2, vecs[v].rd, vecs[v].wr, BASE + vecs[v].off, vecs[v].wd, vecs[v].be,
          rdata, waits, e);
      if (vecs[v].rd) check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rd);
`ifndef MEM_WAIT_RANDOM_EN
      check($sformatf("vec%0d_waits", v), 32'(waits), 32'd2);
`endif
      check($sformatf("vec%0d_err", v), 32'(e), 32'd0);
    end

    // Out-of-range read returns zero and latches err.
    bus(I_W2, 1'b1, 1'b0, BASE + 32'd1024, '0, '0, rdata, waits, e);
    check("oor_read_data", rdata, 32'h0);
    check("oor_read_err", 32'(e), 32'd1);
    bus(I_W2, 1'b1, 1'b0, BASE + 32'd4, '0, '0, rdata, waits, e);
    check("err_sticky_data", rdata, 32'h2402_0010);
    check("err_sticky", 32'(e), 32'd1);

    // read and write together: serviced as read, write discarded.
    bus(I_W1, 1'b1, 1'b1, BASE + 32'd12, 32'h0, 4'hF, rdata, waits, e);
    check("rdwr_data", rdata, 32'h1122_3344);
    check("rdwr_err", 32'(e), 32'd1);
    bus(I_W1, 1'b1, 1'b0, BASE + 32'd12, '0, '0, rdata, waits, e);
    check("rdwr_no_write", rdata, 32'h1122_3344);

    bus(I_W0, 1'b1, 1'b0, BASE + 32'd6, '0, '0, rdata, waits, e);
    check("misalign_data", rdata, 32'h2402_0010);
    check("misalign_err", 32'(e), 32'd1);

    // Below base wraps to an offset whose index bits alias word 255.
    bus(I_W3, 1'b0, 1'b1, BASE - 32'd4, 32'h0BAD_0BAD, 4'hF, rdata, waits, e);
    check("below_base_err", 32'(e), 32'd1);
    bus(I_W3, 1'b1, 1'b0, BASE + 32'd1020, '0, '0, rdata, waits, e);
    check("below_base_dropped", rdata, 32'hCAFE_F00D);

    pulse_reset();
    check("reset_clears_err_w2", 32'(err_s[I_W2]), 32'd0);
    check("reset_clears_err_w1", 32'(err_s[I_W1]), 32'd0);
    bus(I_W2, 1'b1, 1'b0, BASE + 32'd12, '0, '0, rdata, waits, e);
    check("mem_survives_reset", rdata, 32'h11BB_33DD);

    // Master abandons a transfer while in WAIT.
    address[I_W3]  = BASE + 32'd4;
    bus_read[I_W3] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus_read[I_W3] = 1'b0;
    @(posedge clk); #1;
    check("drop_in_wait_err", 32'(err_s[I_W3]), 32'd1);

    // Reset mid-WAIT aborts the write.
    pulse_reset();
    address[I_W3]    = BASE + 32'd20;
    writedata[I_W3]  = 32'hFFFF_FFFF;
    byteenable[I_W3] = 4'hF;
    bus_write[I_W3]  = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1 check("rst_mid_waitreq", 32'(waitreq[I_W3]), 32'd1);
    bus_write[I_W3] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("rst_mid_err", 32'(err_s[I_W3]), 32'd0);
    bus(I_W3, 1'b1, 1'b0, BASE + 32'd20, '0, '0, rdata, waits, e);
    check("rst_mid_word", rdata, 32'h5555_5555);
`ifndef MEM_WAIT_RANDOM_EN
    check("rst_mid_idle_latency", 32'(waits), 32'd3);

    // Zero-wait reads with one idle cycle between requests.
    total = 0;
    for (int k = 0; k < 3; k++) begin
      bus(I_W0, 1'b1, 1'b0, BASE + (k == 0 ? 32'd4 : (k == 1 ? 32'd12 : 32'd1020)),
          '0, '0, rdata, waits, e);
      total += waits;
      check($sformatf("zw_data%0d", k), rdata,
            k == 0 ? 32'h2402_0010 : (k == 1 ? 32'h1122_3344 : 32'hCAFE_F00D));
      @(posedge clk); #1;
    end
    check("zw_waits", 32'(total), 32'd0);

    // Word preloaded at edge N is read by a transfer completing at N+1.
    preload(7, 32'h77AA_77AA);
    bus(I_W0, 1'b1, 1'b0, BASE + 32'd28, '0, '0, rdata, waits, e);
    check("read_after_preload", rdata, 32'h77AA_77AA);

    // Preload and bus write to the same word on the same edge.
    load_en   = 1'b1;
    load_addr = 8'd8;
    load_data = 32'h0BAD_C0DE;
    bus(I_W0, 1'b0, 1'b1, BASE + 32'd32, 32'hFFFF_FFFF, 4'hF, rdata, waits, e);
    load_en = 1'b0;
    bus(I_W0, 1'b1, 1'b0, BASE + 32'd32, '0, '0, rdata, waits, e);
    check("preload_wins", rdata, 32'h0BAD_C0DE);
`else
    pulse_reset();
    lfsr_m = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      bus(I_W1, 1'b1, 1'b0, BASE + 32'd4, '0, '0, rdata, waits, e);
      check($sformatf("rnd_wait%0d", k), 32'(waits), 32'd1 + 32'(lfsr_m[1:0]));
      check($sformatf("rnd_range%0d", k), 32'(waits >= 1 && waits <= 4), 32'd1);
      lfsr_m = {1'b0, lfsr_m[7:1]} ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_mem_model.md
# avalon_mem_model

Parametrised Avalon-MM slave memory model for CPU test benches. Serves instruction fetches and data accesses from a word array mapped at a configurable base address, with a configurable number of wait states. A clocked preload port fills program contents before or during simulation. A sticky error flag reports accesses that break protocol or fall outside the mapped range.

## Interface
Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- DEPTH, 256, number of words; power of two.
- BASE_ADDR, 32'hBFC00000, byte address of word 0.
- WAIT_CYCLES, 1, fixed number of waitrequest-high cycles per transfer (0 allowed).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- address  in  32  byte address from the master.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_W  write data.
- byteenable  in  DATA_W/8  per-byte write enable.
- waitrequest  out  1  stall; the transfer completes on the rising edge where this is 0.
- readdata  out  DATA_W  read data; valid when read=1 and waitrequest=0.
- load_en  in  1  preload strobe, sampled at the rising edge.
- load_addr  in  $clog2(DEPTH)  preload word index.
- load_data  in  DATA_W  preload word.
- err  out  1  sticky error flag.

## Operation
- Word index = (address − BASE_ADDR) >> 2. In range when 0 ≤ offset < DEPTH*4.
- FSM states:
  - IDLE. On read|write, load cnt = WAIT_CYCLES and go to WAIT. If WAIT_CYCLES = 0, go straight to ACCESS behaviour in the same cycle.
  - WAIT. Decrement cnt each cycle; go to ACCESS when cnt reaches 1.
  - ACCESS. Single cycle; the transfer completes here and the FSM returns to IDLE.
- waitrequest = (read|write) && !(ACCESS, or IDLE with WAIT_CYCLES=0).
- Reads: readdata is the array word, read combinationally from the array in ACCESS.
  - Out-of-range read returns 0 and sets err.
- Writes: the array updates at the completing edge, per byteenable bit.
  - Out-of-range write is dropped and sets err.
- Error cases (all set err; err clears only on reset):
  - address[1:0] ≠ 0: low bits ignored.
  - read and write both 1: serviced as a read, write discarded.
  - Master drops read/write while in WAIT: FSM returns to IDLE.
- Preload: at a rising edge with load_en=1, array[load_addr] = load_data.
  - Preload is independent of the FSM.
  - If preload and a completing bus write hit the same word in the same edge, preload wins.
- The array has no reset; contents survive reset.

## Timing
- Reset values: FSM=IDLE, cnt=0, err=0, readdata=0. While reset=0, waitrequest = read|write, so the master stalls.
- Latency: a read issued at edge N completes at edge N+WAIT_CYCLES+1. With WAIT_CYCLES=0, it completes at edge N+1 (zero-wait).
- Back-to-back: a new request is accepted in the cycle after ACCESS. There is no pipelining, so at most one transfer is outstanding.
- Reset asserted mid-WAIT: the FSM aborts to IDLE asynchronously and no write occurs.
- Read-after-preload: a word preloaded at edge N is readable by a transfer completing at edge N+1.

## Configuration
- MEM_WAIT_RANDOM_EN defined:
  - Per-transfer wait = WAIT_CYCLES + lfsr[1:0], giving 0–3 extra cycles.
  - 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset.
  - The LFSR advances once per transfer start in IDLE.
- MEM_WAIT_RANDOM_EN undefined: wait is exactly WAIT_CYCLES; no LFSR logic is present.

## Structure
- Shared package mem_model_pkg:
  - state enum (IDLE, WAIT, ACCESS).
  - LFSR_SEED and LFSR tap constants.
  - Default BASE_ADDR constant, shared with the CPU reset-vector definition.
- One sub-module, mem_wait_lfsr: 8-bit Galois LFSR with enable. Instantiated only under MEM_WAIT_RANDOM_EN.

## Test plan
- Preload / fetch: preload word 1 = 32'h24020010; read BASE_ADDR+4 with WAIT_CYCLES=2 → waitrequest high 2 cycles, then low with readdata=32'h24020010; err=0.
- Byte-lane write: word 3 = 32'h11223344; write 32'hAABBCCDD with byteenable=4'b0101 → read returns 32'h11BB33DD.
- Range / protocol errors:
  - Read BASE_ADDR+DEPTH*4 → readdata=0, err=1; err stays 1 until reset.
  - read=write=1 → serviced as a read, err=1.
- Zero-wait: WAIT_CYCLES=0, three back-to-back reads → waitrequest never high, one word per 2 cycles.
- Reset mid-transfer: write with WAIT_CYCLES=3; drop reset to 0 after 1 wait cycle → FSM in IDLE, target word unchanged, err=0.
- Random waits: with MEM_WAIT_RANDOM_EN and WAIT_CYCLES=1, 16 reads → every wait count lies in 1..4, and the sequence matches the LFSR model seeded with 8'hA5.
